uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources (status, echo, debug).
//  Takes one byte from the winning requester, pulses it into the UART TX, waits for done, then re-arbitrates.
//  Supports a bounded burst lock, so a requester can send a short packet without interleaving.
//  It also has a done-timeout watchdog, so a hung TX cannot deadlock the port.
// PARAMETERS
//  NUM_REQ       4     number of requesters (2..8)
//  MAX_BURST     4     max consecutive bytes granted to one owner before forced rotation (>=1)
//  TIMEOUT_CLKS  4096  clocks to wait for i_Tx_Done before aborting (>= 11*clocks-per-bit)
// PORTS
//  i_Clk         in   1            system clock
//  i_Rst_n       in   1            asynchronous active-low reset
//  i_Req         in   NUM_REQ      per-requester byte-valid, level, held until granted
//  i_Data        in   8*NUM_REQ    requester n byte on [8n+7:8n], stable while i_Req[n]=1
//  o_Grant       out  NUM_REQ      one-hot, 1-cycle pulse: requester's byte consumed
//  o_Tx_DV       out  1            1-cycle pulse to UART TX: o_Tx_Byte valid
//  o_Tx_Byte     out  8            byte to transmit, stable from DV until done/abort
//  i_Tx_Done     in   1            1-cycle pulse from UART TX: stop bit finished
//  o_Busy        out  1            high in SEND and WAIT_DONE
//  o_Timeout     out  1            1-cycle pulse: watchdog abort
// BEHAVIOUR
//  Clock and reset: one clock i_Clk. Async active-low reset i_Rst_n.
//  Reset values: state=ARB, o_Grant=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Timeout=0, last_owner=NUM_REQ-1, burst=0, timer=0.
//  All outputs are registered.
//  States:
//   ARB: i_Req sampled only here; i_Req==0 -> stay.
//    Owner selection when any i_Req is set:
//     - Same owner again if i_Req[owner]=1 and burst<MAX_BURST (burst+1).
//     - Otherwise, first set bit scanning last_owner+1, +2 ... modulo NUM_REQ; burst=1.
//    On selection, same edge: latch o_Tx_Byte from i_Data slice, owner=winner, last_owner=winner, timer=0, -> SEND.
//   SEND (exactly 1 cycle): o_Tx_DV=1 and o_Grant[owner]=1 in this cycle; -> WAIT_DONE.
//   WAIT_DONE: timer increments each cycle.
//    - i_Tx_Done=1 -> ARB.
//    - Else timer==TIMEOUT_CLKS-1 -> o_Timeout pulse, burst=MAX_BURST (forces rotation), -> ARB.
//    - i_Tx_Done and timeout on the same cycle: done wins, no o_Timeout.
//  Latency: request seen in ARB -> DV/Grant the next cycle. Back-to-back bytes: done -> ARB (1 cycle) -> SEND.
//  Handshake:
//   - A requester may change i_Data or drop i_Req in the cycle after its o_Grant.
//   - Dropping i_Req before grant withdraws the request; a request seen only outside ARB is ignored.
//   - i_Tx_Done outside WAIT_DONE is ignored.
//  Burst:
//   - Owner keeps priority only while i_Req stays high and burst<MAX_BURST.
//   - Owner dropping i_Req in ARB ends the burst.
//   - MAX_BURST=1 gives pure round-robin.
//  Arithmetic: timer width clog2(TIMEOUT_CLKS), no wrap, saturates by state exit; burst width clog2(MAX_BURST+1).
//  Reset mid-transfer: returns to ARB immediately, no o_Grant/o_Tx_DV glitch.
//   The UART TX is reset by the same i_Rst_n.
// TESTING
//  1. Reset, i_Req=4'b0001, data 8'h41, done 20 clks after DV -> DV+Grant[0] 1 clk after req, o_Tx_Byte=8'h41, o_Busy 1 until done.
//  2. i_Req=4'b1111 held, MAX_BURST=1 -> grants 0,1,2,3,0 in order; each DV 2 clks after prior i_Tx_Done.
//  3. i_Req[2] held for 6 bytes, i_Req[0] also high, MAX_BURST=4 -> grant 2,2,2,2,0,2.
//  4. No i_Tx_Done after DV -> o_Timeout pulse exactly TIMEOUT_CLKS clks after DV, back to ARB, next grant goes to another requester if pending.
//  5. i_Tx_Done on the timeout cycle -> no o_Timeout.
//     i_Tx_Done pulsed while in ARB -> ignored, no state change.
//  6. i_Rst_n low during WAIT_DONE -> all outputs 0 asynchronously; after release, requester 0 wins a 4'b1111 request.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with a bounded burst lock and a done-timeout watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 4,
  parameter int TIMEOUT_CLKS = 4096
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req,
  input  logic [8*NUM_REQ-1:0] i_Data,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic [1:0]           o_State
);

  // Handshake: i_Req[n] is a level held until o_Grant[n] pulses; i_Data slice n
  // must be stable while i_Req[n]=1 and may change the cycle after the grant.
  // o_Tx_DV pulses once per byte; i_Tx_Done is only honoured in WAIT_DONE.

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [OW-1:0] OWNER_INIT = OW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [OW-1:0]   last_owner;
  logic [BW-1:0]   burst;
  logic [TW-1:0]   timer;

  logic [OW-1:0]   winner;
  logic [OW-1:0]   sel;
  logic            found;
  logic            keep;
  logic            any_req;
  logic            timeout_hit;

  logic            dv_d;
  logic [NUM_REQ-1:0] grant_d;
  logic            busy_d;
  logic            timeout_d;

  assign any_req = |i_Req;
  assign o_State = state;

  // burst==0 means no current owner, so the rotation scan always decides.
  always_comb begin
    winner = last_owner;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && i_Req[(int'(last_owner) + k) % NUM_REQ]) begin
        found  = 1'b1;
        winner = OW'((int'(last_owner) + k) % NUM_REQ);
      end
    end
    keep = (burst != '0) && (burst < BURST_MAX) && i_Req[last_owner];
    sel  = keep ? last_owner : winner;
  end

  assign timeout_hit = (state == WAIT_DONE) && !i_Tx_Done && (timer == TIMER_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) state <= ARB;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB:       if (any_req) state_next = SEND;
      SEND:      state_next = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done || timeout_hit) state_next = ARB;
      default:   state_next = ARB;
    endcase
  end

  always_comb begin
    dv_d      = (state == ARB) && any_req;
    grant_d   = dv_d ? (NUM_REQ'(1) << sel) : '0;
    busy_d    = (state_next != ARB);
    timeout_d = timeout_hit;
  end

  // The timer also counts the SEND cycle, so the abort lands TIMEOUT_CLKS after DV.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Grant    <= '0;
      o_Tx_DV    <= 1'b0;
      o_Tx_Byte  <= 8'h00;
      o_Busy     <= 1'b0;
      o_Timeout  <= 1'b0;
      last_owner <= OWNER_INIT;
      burst      <= '0;
      timer      <= '0;
    end else begin
      o_Grant   <= grant_d;
      o_Tx_DV   <= dv_d;
      o_Busy    <= busy_d;
      o_Timeout <= timeout_d;
      case (state)
        ARB: begin
          if (any_req) begin
            o_Tx_Byte  <= i_Data[int'(sel)*8 +: 8];
            last_owner <= sel;
            burst      <= keep ? burst + BW'(1) : BW'(1);
            timer      <= '0;
          end else begin
            burst <= '0;
          end
        end
        SEND: timer <= timer + TW'(1);
        WAIT_DONE: begin
          if (!i_Tx_Done && !timeout_hit) timer <= timer + TW'(1);
          if (timeout_hit) burst <= BURST_MAX;
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with burst lock (MAX_BURST=4)
// and one pure round-robin instance (MAX_BURST=1) share the same stimulus.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data;
  logic        done;

  logic [3:0]  grant,    rr_grant;
  logic        dv,       rr_dv;
  logic [7:0]  tx_byte,  rr_tx_byte;
  logic        busy,     rr_busy;
  logic        timeout,  rr_timeout;
  logic [1:0]  state,    rr_state;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];
  int cnt[N];
  int sent[N];

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .TIMEOUT_CLKS(T)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Data(data),
    .o_Grant(grant), .o_Tx_DV(dv), .o_Tx_Byte(tx_byte), .i_Tx_Done(done),
    .o_Busy(busy), .o_Timeout(timeout), .o_State(state)
  );

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(1), .TIMEOUT_CLKS(T)) dut_rr (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Req(req), .i_Data(data),
    .o_Grant(rr_grant), .o_Tx_DV(rr_dv), .o_Tx_Byte(rr_tx_byte), .i_Tx_Done(done),
    .o_Busy(rr_busy), .o_Timeout(rr_timeout), .o_State(rr_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req[i] = (cnt[i] > 0);
      data[8*i +: 8] = 8'h41 + 8'(16*i) + 8'(sent[i]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    done  = 1'b0;
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      sent[i] = 0;
    end
    drive_req();
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Waits for DV, checks grant/byte against the scoreboard, then either pulses
  // done dly cycles after DV (dly>=1) or lets the watchdog fire (dly<0).
  task automatic run_byte(input int exp_lat, input int dly, input int exp_rr);
    int n;
    logic [3:0] e;
    n = 0;
    while (!dv && n < 40) begin
      step();
      n++;
    end
    if (!dv) begin
      check("dv_wait", dv, 1);
      return;
    end
    if (exp_lat >= 0) check("dv_lat", n, exp_lat);
    e = exp_q.pop_front();
    check("grant", grant, 32'(4'b0001 << e));
    check("tx_byte", tx_byte, 8'h41 + 16*e + sent[e]);
    check("busy_send", busy, 1);
    if (exp_rr >= 0) check("rr_grant", rr_grant, 32'(4'b0001 << exp_rr));
    cnt[e]--;
    sent[e]++;
    step();
    drive_req();
    check("dv_pulse", {dv, grant}, 0);
    if (dly >= 1) begin
      repeat (dly - 1) step();
      check("busy_wait", busy, 1);
      done = 1'b1;
      step();
      done = 1'b0;
      check("busy_done", busy, 0);
      check("no_timeout", timeout, 0);
    end else begin
      n = 1;
      while (!timeout && n < T + 8) begin
        step();
        n++;
      end
      check("to_lat", n, T);
      check("to_busy", busy, 0);
    end
  endtask

  int dut_seq[5] = '{0, 0, 0, 0, 1};
  int rr_seq[5]  = '{0, 1, 2, 3, 0};
  int burst_seq[6] = '{2, 2, 2, 2, 0, 2};

  initial begin
    req  = '0;
    data = '0;
    done = 1'b0;

    // Reset state and a single byte with a slow done.
    do_reset();
    check("rst_outputs", {dv, grant, busy, timeout, tx_byte, state}, 0);
    cnt[0] = 1;
    drive_req();
    exp_q.push_back(4'd0);
    run_byte(1, 20, 0);
    check("idle_after", {dv, busy, state}, 0);

    // All requesters held: burst lock vs pure round-robin.
    do_reset();
    for (int i = 0; i < N; i++) cnt[i] = 100;
    drive_req();
    for (int i = 0; i < 5; i++) exp_q.push_back(4'(dut_seq[i]));
    for (int i = 0; i < 5; i++) run_byte(1, 3, rr_seq[i]);

    // Requester 2 bursts six bytes while requester 0 wants one.
    do_reset();
    cnt[2] = 6;
    drive_req();
    for (int i = 0; i < 6; i++) exp_q.push_back(4'(burst_seq[i]));
    run_byte(1, 2, -1);
    cnt[0] = 1;
    drive_req();
    for (int i = 1; i < 6; i++) run_byte(1, 2, -1);

    // Watchdog abort forces rotation away from requester 0.
    do_reset();
    cnt[0] = 3;
    cnt[1] = 1;
    drive_req();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd0);
    run_byte(1, -1, -1);
    run_byte(1, 3, -1);
    run_byte(1, 3, -1);

    // Done on the timeout cycle wins: no abort, owner keeps its burst.
    do_reset();
    cnt[0] = 2;
    cnt[1] = 1;
    drive_req();
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    run_byte(1, T - 1, -1);
    run_byte(1, 2, -1);
    run_byte(1, 2, -1);

    // Done while idle in ARB is ignored.
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    check("done_in_arb", {dv, grant, busy, timeout, state}, 0);
    step();
    check("done_in_arb2", {dv, busy, timeout, state}, 0);

    // Asynchronous reset in WAIT_DONE, then requester 0 wins a full request.
    do_reset();
    cnt[2] = 1;
    drive_req();
    step();
    check("pre_rst_grant", grant, 32'h4);
    repeat (3) step();
    check("pre_rst_state", state, 2);
    rst_n = 1'b0;
    #1;
    check("rst_async", {dv, grant, busy, timeout, tx_byte, state}, 0);
    for (int i = 0; i < N; i++) begin
      cnt[i]  = 0;
      sent[i] = 0;
    end
    drive_req();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < N; i++) cnt[i] = 1;
    drive_req();
    exp_q.push_back(4'd0);
    run_byte(1, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
